// File: rtl/ascon_pkg.sv
// Shared constants and types for the Ascon-Hash sponge controller.
package ascon_pkg;

   localparam logic [63:0] IV_HASH  = 64'h00400c0000000100;
   localparam logic [63:0] IV_HASHA = 64'h00400c0400000100;
   localparam logic [7:0]  PAD_BYTE = 8'h80;
   localparam logic [63:0] PAD_WORD = {PAD_BYTE, 56'h0};

   // Index 0 is x0, the rate word.
   typedef logic [4:0][63:0] ascon_state_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT_PERM,
      ST_ABSORB,
      ST_ABS_PERM,
      ST_SQZ_PERM,
      ST_OUT
   } sponge_state_t;

endpackage

// File: rtl/ascon_pad.sv
// 10* padding of a big-endian message word: keep the top n bytes, put PAD_BYTE at byte n, zero below.
// For n >= 8 the word passes through unchanged.
module ascon_pad
   import ascon_pkg::*;
(
   input  logic [63:0] d,
   input  logic [3:0]  n,
   output logic [63:0] q
);

   always_comb begin
      // NOTE: q gets a default before the loop so no bit path can infer a latch.
      q = '0;
      for (int i = 0; i < 8; i++) begin
         if (4'(i) < n) begin
            q[63-8*i -: 8] = d[63-8*i -: 8];
         end else if (4'(i) == n) begin
            q[63-8*i -: 8] = PAD_BYTE;
         end
      end
   end

endmodule

// File: rtl/ascon_hash_sponge.sv
// Ascon-Hash sponge controller: owns x0..x4, absorbs and pads message words, sequences the external
// permutation core and squeezes the digest. Define ASCON_HASHA_EN to add the Ascon-Hasha mode (mode_a).
module ascon_hash_sponge
   import ascon_pkg::*;
#(
   parameter int OUT_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
`ifdef ASCON_HASHA_EN
   input  logic        mode_a,
`endif
   input  logic        msg_valid,
   output logic        msg_ready,
   input  logic [63:0] msg_data,
   input  logic        msg_last,
   input  logic [3:0]  msg_bytes,
   output logic        dig_valid,
   input  logic        dig_ready,
   output logic [63:0] dig_data,
   output logic        dig_last,
   output logic        perm_en_p12,
   output logic        perm_en_p8,
   output logic [63:0] perm_x0_o,
   output logic [63:0] perm_x1_o,
   output logic [63:0] perm_x2_o,
   output logic [63:0] perm_x3_o,
   output logic [63:0] perm_x4_o,
   input  logic [63:0] perm_x0_i,
   input  logic [63:0] perm_x1_i,
   input  logic [63:0] perm_x2_i,
   input  logic [63:0] perm_x3_i,
   input  logic [63:0] perm_x4_i,
   input  logic        perm_done
);

   localparam logic [3:0] LAST_WORD = 4'(OUT_WORDS - 1);

   sponge_state_t state_q, state_d;
   ascon_state_t  x_q, x_d;
   ascon_state_t  perm_in;
   logic          pad_pending_q, pad_pending_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          perm_gap_q;
   logic          in_perm, perm_hit, use_p8;
   logic [3:0]    bytes_eff;
   logic [63:0]   padded;
   logic [63:0]   start_iv;

   assign perm_in   = {perm_x4_i, perm_x3_i, perm_x2_i, perm_x1_i, perm_x0_i};
   assign bytes_eff = (msg_bytes > 4'd8) ? 4'd8 : msg_bytes;

   ascon_pad u_pad (
      .d (msg_data),
      .n (bytes_eff),
      .q (padded)
   );

   // The enable drops for one cycle after every done so the core restarts at round 0,
   // even when ABS_PERM hands straight over to SQZ_PERM.
   assign in_perm  = ((state_q == ST_INIT_PERM) || (state_q == ST_ABS_PERM) ||
                      (state_q == ST_SQZ_PERM)) && !perm_gap_q;
   assign perm_hit = in_perm && perm_done;

`ifdef ASCON_HASHA_EN
   logic mode_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= 1'b0;
      end else if ((state_q == ST_IDLE) && start) begin
         mode_q <= mode_a;
      end
   end

   assign start_iv = mode_a ? IV_HASHA : IV_HASH;
   // Hasha: init and the first squeeze use p12, every other permutation uses p8.
   assign use_p8   = mode_q && ((state_q == ST_ABS_PERM) ||
                                ((state_q == ST_SQZ_PERM) && (cnt_q != 4'd0)));
`else
   assign start_iv = IV_HASH;
   assign use_p8   = 1'b0;
`endif

   assign perm_en_p12 = in_perm && !use_p8;
   assign perm_en_p8  = in_perm && use_p8;

   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      pad_pending_d = pad_pending_q;
      cnt_d         = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               x_d           = '0;
               x_d[0]        = start_iv;
               pad_pending_d = 1'b0;
               cnt_d         = 4'd0;
               state_d       = ST_INIT_PERM;
            end
         end
         ST_INIT_PERM: begin
            if (perm_hit) begin
               x_d     = perm_in;
               state_d = ST_ABSORB;
            end
         end
         ST_ABSORB: begin
            if (msg_valid) begin
               if (!msg_last) begin
                  x_d[0]  = x_q[0] ^ msg_data;
                  state_d = ST_ABS_PERM;
               end else if (bytes_eff != 4'd8) begin
                  x_d[0]  = x_q[0] ^ padded;
                  state_d = ST_SQZ_PERM;
               end else begin
                  // A full final word still needs a block holding only the pad bit.
                  x_d[0]        = x_q[0] ^ msg_data;
                  pad_pending_d = 1'b1;
                  state_d       = ST_ABS_PERM;
               end
            end
         end
         ST_ABS_PERM: begin
            if (perm_hit) begin
               x_d = perm_in;
               if (pad_pending_q) begin
                  x_d[0]        = perm_x0_i ^ PAD_WORD;
                  pad_pending_d = 1'b0;
                  state_d       = ST_SQZ_PERM;
               end else begin
                  state_d = ST_ABSORB;
               end
            end
         end
         ST_SQZ_PERM: begin
            if (perm_hit) begin
               x_d     = perm_in;
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            if (dig_ready) begin
               if (cnt_q == LAST_WORD) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d   = cnt_q + 4'd1;
                  state_d = ST_SQZ_PERM;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the 320-bit state is reset as well: it drives the core inputs and dig_data directly.
         state_q       <= ST_IDLE;
         x_q           <= '0;
         pad_pending_q <= 1'b0;
         cnt_q         <= 4'd0;
         perm_gap_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q       <= state_d;
         x_q           <= x_d;
         pad_pending_q <= pad_pending_d;
         cnt_q         <= cnt_d;
         perm_gap_q    <= perm_hit;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign msg_ready = (state_q == ST_ABSORB);
   assign dig_valid = (state_q == ST_OUT);
   assign dig_last  = (state_q == ST_OUT) && (cnt_q == LAST_WORD);
   assign dig_data  = x_q[0];

   assign perm_x0_o = x_q[0];
   assign perm_x1_o = x_q[1];
   assign perm_x2_o = x_q[2];
   assign perm_x3_o = x_q[3];
   assign perm_x4_o = x_q[4];

   // Hardware folds msg_bytes > 8 to 8; a producer sending it is broken.
   a_msg_bytes_legal: assert property (@(posedge clk) disable iff (!rst_n)
      (msg_ready && msg_valid && msg_last) |-> (msg_bytes <= 4'd8));

endmodule

// File: tb/tb_ascon_hash_sponge.sv
// Directed bench for ascon_hash_sponge with a behavioural Ascon permutation core and a byte-level hash model.
`timescale 1ns/1ps
module tb_ascon_hash_sponge;

   localparam int OUT_WORDS = 4;
   localparam logic [63:0] TB_IV_HASH  = 64'h00400c0000000100;
   localparam logic [63:0] TB_IV_HASHA = 64'h00400c0400000100;
   localparam logic [63:0] KAT_EMPTY [4] = '{64'h7346bc14f036e87a, 64'he03d0997913088f5,
                                             64'hf68411434b3cf8b5, 64'h4fa796a80d251f91};
   localparam logic [63:0] KAT_INIT [5]  = '{64'hee9398aadb67f03d, 64'h8bb21831c60f1002,
                                             64'hb48a92db98d5da62, 64'h43189921b8f8e3e8,
                                             64'h348fa5c9d525e140};

   typedef logic [4:0][63:0] st_t;

   logic        clk, rst_n, start, busy;
`ifdef ASCON_HASHA_EN
   logic        mode_a;
`endif
   logic        msg_valid, msg_ready, msg_last;
   logic [63:0] msg_data;
   logic [3:0]  msg_bytes;
   logic        dig_valid, dig_ready, dig_last;
   logic [63:0] dig_data;
   logic        perm_en_p12, perm_en_p8, perm_done;
   logic [63:0] perm_x0_o, perm_x1_o, perm_x2_o, perm_x3_o, perm_x4_o;
   logic [63:0] perm_x0_i, perm_x1_i, perm_x2_i, perm_x3_i, perm_x4_i;

   int          tests_run = 0;
   int          tests_failed = 0;
   logic [7:0]  msg_buf [64];
   logic [63:0] exp_dig [OUT_WORDS];
   logic [63:0] got [OUT_WORDS];
   logic        got_last [OUT_WORDS];
   int          got_n, stall_bad, ready_dropped;

   always #5 clk = ~clk;

   ascon_hash_sponge #(.OUT_WORDS(OUT_WORDS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
`ifdef ASCON_HASHA_EN
      .mode_a(mode_a),
`endif
      .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
      .msg_last(msg_last), .msg_bytes(msg_bytes),
      .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data), .dig_last(dig_last),
      .perm_en_p12(perm_en_p12), .perm_en_p8(perm_en_p8),
      .perm_x0_o(perm_x0_o), .perm_x1_o(perm_x1_o), .perm_x2_o(perm_x2_o),
      .perm_x3_o(perm_x3_o), .perm_x4_o(perm_x4_o),
      .perm_x0_i(perm_x0_i), .perm_x1_i(perm_x1_i), .perm_x2_i(perm_x2_i),
      .perm_x3_i(perm_x3_i), .perm_x4_i(perm_x4_i),
      .perm_done(perm_done)
   );

   function automatic logic [63:0] ror(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   function automatic st_t ascon_p(input st_t s, input int nr);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
      for (int r = 12 - nr; r < 12; r++) begin
         x2 ^= {56'h0, 4'(15 - r), 4'(r)};
         x0 ^= x4; x4 ^= x3; x2 ^= x1;
         t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
         x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
         x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
         x0 ^= ror(x0, 19) ^ ror(x0, 28);
         x1 ^= ror(x1, 61) ^ ror(x1, 39);
         x2 ^= ror(x2, 1)  ^ ror(x2, 6);
         x3 ^= ror(x3, 10) ^ ror(x3, 17);
         x4 ^= ror(x4, 7)  ^ ror(x4, 41);
      end
      return {x4, x3, x2, x1, x0};
   endfunction

   // Behavioural core: 3 cycles for p12, 2 for p8, then a one-cycle done; garbage outputs otherwise.
   st_t core_out;
   int  core_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_cnt  <= 0;
         perm_done <= 1'b0;
         core_out  <= '0;
      end else if (perm_done) begin
         perm_done <= 1'b0;
         core_cnt  <= 0;
      end else if (perm_en_p12 || perm_en_p8) begin
         if (core_cnt == (perm_en_p8 ? 1 : 2)) begin
            perm_done <= 1'b1;
            core_out  <= ascon_p({perm_x4_o, perm_x3_o, perm_x2_o, perm_x1_o, perm_x0_o},
                                 perm_en_p8 ? 8 : 12);
         end
         core_cnt <= core_cnt + 1;
      end else begin
         core_cnt <= 0;
      end
   end
   assign perm_x0_i = perm_done ? core_out[0] : 64'hdead_beef_0000_0000;
   assign perm_x1_i = perm_done ? core_out[1] : 64'hdead_beef_1111_1111;
   assign perm_x2_i = perm_done ? core_out[2] : 64'hdead_beef_2222_2222;
   assign perm_x3_i = perm_done ? core_out[3] : 64'hdead_beef_3333_3333;
   assign perm_x4_i = perm_done ? core_out[4] : 64'hdead_beef_4444_4444;

   // Per-hash observations, cleared on every accepted start.
   int runs, hs, runs_at_dv;
   bit seen_dv, p8_late;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         runs <= 0; hs <= 0; runs_at_dv <= 0; seen_dv <= 1'b0; p8_late <= 1'b0;
      end else if (start && !busy) begin
         runs <= 0; hs <= 0; runs_at_dv <= 0; seen_dv <= 1'b0; p8_late <= 1'b0;
      end else begin
         if (perm_done) runs <= runs + 1;
         if (dig_valid && dig_ready) hs <= hs + 1;
         if (dig_valid && !seen_dv) begin
            seen_dv    <= 1'b1;
            runs_at_dv <= runs;
         end
         if (perm_en_p8 && hs > 0) p8_late <= 1'b1;
      end
   end

   // Protocol watch over the whole run: enable must drop after done, never both enables at once.
   int  gap_bad = 0;
   int  both_bad = 0;
   logic done_d = 1'b0;
   always @(posedge clk) begin
      done_d <= perm_done;
      if (done_d && (perm_en_p12 || perm_en_p8)) gap_bad <= gap_bad + 1;
      if (perm_en_p12 && perm_en_p8) both_bad <= both_bad + 1;
   end

   function automatic logic [389:0] out_vec();
      return {busy, msg_ready, dig_valid, dig_last, perm_en_p12, perm_en_p8, dig_data,
              perm_x0_o, perm_x1_o, perm_x2_o, perm_x3_o, perm_x4_o};
   endfunction

   task automatic fill_msg(input int mul, input int add);
      for (int i = 0; i < 64; i++) msg_buf[i] = 8'(i * mul + add);
   endtask

   task automatic hash_model(input int len, input bit ha);
      st_t s;
      logic [63:0] blk;
      int nblk, pb;
      pb = ha ? 8 : 12;
      s = '0;
      s[0] = ha ? TB_IV_HASHA : TB_IV_HASH;
      s = ascon_p(s, 12);
      nblk = len / 8 + 1;
      for (int b = 0; b < nblk; b++) begin
         blk = '0;
         for (int k = 0; k < 8; k++) begin
            if (b * 8 + k < len) blk[63-8*k -: 8] = msg_buf[b * 8 + k];
            else if (b * 8 + k == len) blk[63-8*k -: 8] = 8'h80;
         end
         s[0] ^= blk;
         s = ascon_p(s, (b == nblk - 1) ? 12 : pb);
      end
      for (int w = 0; w < OUT_WORDS; w++) begin
         exp_dig[w] = s[0];
         if (w < OUT_WORDS - 1) s = ascon_p(s, pb);
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_ready(output bit ok);
      int cyc;
      cyc = 0;
      while (!msg_ready && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      ok = msg_ready;
   endtask

   task automatic send_msg(input int len, input int idle, output bit ok);
      int nw, nb;
      bit r;
      logic [63:0] w;
      nw = (len == 0) ? 1 : (len + 7) / 8;
      ok = 1'b1;
      ready_dropped = 0;
      wait_ready(r);
      if (!r) begin ok = 1'b0; return; end
      for (int i = 0; i < idle; i++) begin
         @(negedge clk);
         if (!msg_ready) ready_dropped++;
      end
      for (int k = 0; k < nw; k++) begin
         wait_ready(r);
         if (!r) begin ok = 1'b0; return; end
         nb = len - 8 * k;
         if (nb > 8) nb = 8;
         for (int b = 0; b < 8; b++) w[63-8*b -: 8] = (b < nb) ? msg_buf[8 * k + b] : 8'ha5;
         msg_data  = w;
         msg_last  = (k == nw - 1);
         msg_bytes = (k == nw - 1) ? 4'(nb) : 4'd3;
         msg_valid = 1'b1;
         @(negedge clk);
         msg_valid = 1'b0;
         msg_last  = 1'b0;
      end
   endtask

   task automatic collect(input bit rnd, input bit start_on_last, output bit ok);
      int cyc;
      bit stalled;
      logic [63:0] sd;
      logic sl;
      got_n = 0; stall_bad = 0; stalled = 1'b0; cyc = 0; ok = 1'b1;
      sd = '0; sl = 1'b0;
      while (got_n < OUT_WORDS) begin
         if (cyc >= 3000) begin ok = 1'b0; break; end
         dig_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stalled && (!dig_valid || dig_data !== sd || dig_last !== sl)) stall_bad++;
         stalled = 1'b0;
         if (dig_valid && dig_ready) begin
            got[got_n] = dig_data;
            got_last[got_n] = dig_last;
            if (start_on_last && got_n == OUT_WORDS - 1) start = 1'b1;
            got_n++;
         end else if (dig_valid) begin
            stalled = 1'b1;
            sd = dig_data;
            sl = dig_last;
         end
         @(negedge clk);
         start = 1'b0;
         cyc++;
      end
      dig_ready = 1'b0;
   endtask

   task automatic test_reset();
      tests_run++;
      if (out_vec() !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h required 0", out_vec());
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if ({busy, msg_ready, dig_valid, perm_en_p12, perm_en_p8} !== 5'b0) begin
         tests_failed++;
         $display("FAIL idle_after_reset: got %b required 00000",
                  {busy, msg_ready, dig_valid, perm_en_p12, perm_en_p8});
      end
   endtask

   task automatic test_init_state();
      bit ok;
      logic [63:0] xs [5];
      do_start();
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL busy_after_start: got %b required 1", busy);
      end
      wait_ready(ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL init_timeout: got msg_ready=%b required 1", msg_ready);
      end
      xs = '{perm_x0_o, perm_x1_o, perm_x2_o, perm_x3_o, perm_x4_o};
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if (xs[i] !== KAT_INIT[i]) begin
            tests_failed++;
            $display("FAIL init_x%0d: got %h required %h", i, xs[i], KAT_INIT[i]);
         end
      end
      send_msg(0, 0, ok);
      collect(1'b0, 1'b0, ok);
   endtask

   task automatic test_empty(input string tag);
      bit ok;
      do_start();
      send_msg(0, 0, ok);
      collect(1'b0, 1'b1, ok);
      tests_run++;
      if (!ok || got_n != OUT_WORDS) begin
         tests_failed++;
         $display("FAIL %s_timeout: got %0d words required %0d", tag, got_n, OUT_WORDS);
      end
      for (int w = 0; w < OUT_WORDS; w++) begin
         tests_run++;
         if (got[w] !== KAT_EMPTY[w] || got_last[w] !== (w == OUT_WORDS - 1)) begin
            tests_failed++;
            $display("FAIL %s_word%0d: got %h last=%b required %h last=%b", tag, w,
                     got[w], got_last[w], KAT_EMPTY[w], (w == OUT_WORDS - 1));
         end
      end
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s_busy_drop: got %b required 0", tag, busy);
      end
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || perm_en_p12 !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s_start_on_last_ignored: got busy=%b en=%b required 0 0", tag, busy, perm_en_p12);
      end
      tests_run++;
      if (runs_at_dv != 2) begin
         tests_failed++;
         $display("FAIL %s_perm_runs: got %0d required 2", tag, runs_at_dv);
      end
   endtask

   task automatic run_hash(input string tag, input int len, input int idle, input bit rnd,
                           input int runs_req);
      bit ok;
      hash_model(len, 1'b0);
      do_start();
      send_msg(len, idle, ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL %s_absorb_timeout: got msg_ready=%b required 1", tag, msg_ready);
      end
      collect(rnd, 1'b0, ok);
      for (int w = 0; w < OUT_WORDS; w++) begin
         tests_run++;
         if (got[w] !== exp_dig[w] || got_last[w] !== (w == OUT_WORDS - 1)) begin
            tests_failed++;
            $display("FAIL %s_word%0d: got %h last=%b required %h last=%b", tag, w,
                     got[w], got_last[w], exp_dig[w], (w == OUT_WORDS - 1));
         end
      end
      if (runs_req > 0) begin
         tests_run++;
         if (runs_at_dv != runs_req) begin
            tests_failed++;
            $display("FAIL %s_perm_runs: got %0d required %0d", tag, runs_at_dv, runs_req);
         end
      end
   endtask

   task automatic test_full_word();
      fill_msg(1, 0);
      run_hash("full_word", 8, 0, 1'b0, 3);
   endtask

   task automatic test_multi_word();
      int lens [3] = '{7, 16, 23};
      fill_msg(5, 17);
      foreach (lens[i]) run_hash($sformatf("len%0d", lens[i]), lens[i], 0, 1'b0, 0);
   endtask

   task automatic test_back_to_back_stall();
      fill_msg(7, 3);
      run_hash("stall", 13, 20, 1'b1, 0);
      tests_run++;
      if (ready_dropped != 0 || stall_bad != 0) begin
         tests_failed++;
         $display("FAIL stall_stability: got ready_drops=%0d unstable=%0d required 0 0",
                  ready_dropped, stall_bad);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int cyc, bad;
      do_start();
      send_msg(0, 0, ok);
      cyc = 0;
      while (!perm_en_p12 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if (out_vec() !== '0) begin
         tests_failed++;
         $display("FAIL reset_mid_outputs: got %h required 0", out_vec());
      end
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy || dig_valid || perm_en_p12 || perm_en_p8) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL reset_mid_quiet: got %0d active cycles required 0", bad);
      end
      test_empty("after_reset");
   endtask

`ifdef ASCON_HASHA_EN
   task automatic test_hasha();
      bit ok;
      hash_model(0, 1'b1);
      mode_a = 1'b1;
      do_start();
      mode_a = 1'b0;
      send_msg(0, 0, ok);
      collect(1'b0, 1'b0, ok);
      for (int w = 0; w < OUT_WORDS; w++) begin
         tests_run++;
         if (got[w] !== exp_dig[w]) begin
            tests_failed++;
            $display("FAIL hasha_word%0d: got %h required %h", w, got[w], exp_dig[w]);
         end
      end
      tests_run++;
      if (p8_late !== 1'b1) begin
         tests_failed++;
         $display("FAIL hasha_p8_in_squeeze: got %b required 1", p8_late);
      end
   endtask
`endif

   initial begin
      clk = 1'b0; rst_n = 1'b0; start = 1'b0;
      msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0; msg_bytes = '0; dig_ready = 1'b0;
`ifdef ASCON_HASHA_EN
      mode_a = 1'b0;
`endif
      #23;
      test_reset();
      test_init_state();
      test_empty("empty");
      test_full_word();
      test_multi_word();
      test_back_to_back_stall();
      test_reset_mid();
`ifdef ASCON_HASHA_EN
      test_hasha();
`endif
      tests_run++;
      if (gap_bad != 0 || both_bad != 0) begin
         tests_failed++;
         $display("FAIL perm_enable_protocol: got gap=%0d both=%0d required 0 0", gap_bad, both_bad);
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
